// File: rtl/snes_pkg.sv
// ============================================================================
// snes_pkg : shared FSM states, frame sizes and button bit positions
// Rev 1.0
// ============================================================================
`default_nettype none

package snes_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        SETUP  = 3'd2,
        CLK_LO = 3'd3,
        CLK_HI = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam int NUM_BITS    = 16;
    localparam int NUM_BUTTONS = 12;

    // Bit positions inside the parallel button word (1 = pressed)
    localparam int BTN_B      = 11;
    localparam int BTN_Y      = 10;
    localparam int BTN_SELECT = 9;
    localparam int BTN_START  = 8;
    localparam int BTN_UP     = 7;
    localparam int BTN_DOWN   = 6;
    localparam int BTN_LEFT   = 5;
    localparam int BTN_RIGHT  = 4;
    localparam int BTN_A      = 3;
    localparam int BTN_X      = 2;
    localparam int BTN_L      = 1;
    localparam int BTN_R      = 0;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// sync_2ff : two-flop synchronizer for a single asynchronous pin input
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/snes_ctrl_reader.sv
// ============================================================================
// snes_ctrl_reader : polls one SNES pad per frame and outputs a 12-bit word.
// Optional macro SNES_FRAME_CHECK_EN drops frames whose trailer bits read low.
// Rev 1.0
// ============================================================================
`default_nettype none

module snes_ctrl_reader
    import snes_pkg::*;
#(
    parameter int HALF_TICKS  = 288,
    parameter int FRAME_TICKS = 800000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   ser_data,
    output logic                   ctrl_latch,
    output logic                   ctrl_clk,
    output logic [NUM_BUTTONS-1:0] p1data,
    output logic                   p1data_valid,
    output logic                   busy
);

    localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int CW = (2 * HALF_TICKS > 1) ? $clog2(2 * HALF_TICKS) : 1;
    localparam int BW = $clog2(NUM_BITS);

    localparam logic [TW-1:0] c_FRAME_LAST = TW'(FRAME_TICKS - 1);
    localparam logic [CW-1:0] c_HALF_LAST  = CW'(HALF_TICKS - 1);
    localparam logic [CW-1:0] c_LATCH_LAST = CW'(2 * HALF_TICKS - 1);
    localparam logic [BW-1:0] c_BIT_LAST   = BW'(NUM_BITS - 1);

    logic                   w_ser;
    logic                   w_start;
    logic [TW-1:0]          timer_q;
    logic [TW-1:0]          timer_d;
    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [BW-1:0]          bitcnt_q;
    logic [NUM_BITS-1:0]    shift_q;
    logic                   latch_q;
    logic                   clk_q;
    logic [NUM_BUTTONS-1:0] p1data_q;
    logic                   valid_q;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_ser (
        .clk   (clk),
        .rst_n (reset_n),
        .d_i   (ser_data),
        .q_o   (w_ser)
    );

    // Free-running frame timer; it keeps counting during a transfer so the
    // poll period stays fixed regardless of how long a transfer takes.
    always_comb begin
        timer_d = (timer_q == c_FRAME_LAST) ? '0 : timer_q + 1'b1;
    end

    assign w_start = (timer_q == c_FRAME_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            latch_q  <= 1'b0;
            clk_q    <= 1'b1;
            p1data_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            cnt_q   <= cnt_q + 1'b1;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (w_start) begin
                        latch_q <= 1'b1;
                        state_q <= LATCH;
                    end
                end
                LATCH: begin
                    if (cnt_q == c_LATCH_LAST) begin
                        cnt_q   <= '0;
                        latch_q <= 1'b0;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == c_HALF_LAST) begin
                        cnt_q    <= '0;
                        shift_q  <= {shift_q[NUM_BITS-2:0], w_ser};
                        bitcnt_q <= '0;
                        clk_q    <= 1'b0;
                        state_q  <= CLK_LO;
                    end
                end
                CLK_LO: begin
                    if (cnt_q == c_HALF_LAST) begin
                        cnt_q   <= '0;
                        clk_q   <= 1'b1;
                        state_q <= CLK_HI;
                    end
                end
                CLK_HI: begin
                    if (cnt_q == c_HALF_LAST) begin
                        cnt_q <= '0;
                        if (bitcnt_q != c_BIT_LAST) begin
                            shift_q  <= {shift_q[NUM_BITS-2:0], w_ser};
                            bitcnt_q <= bitcnt_q + 1'b1;
                            clk_q    <= 1'b0;
                            state_q  <= CLK_LO;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
`ifdef SNES_FRAME_CHECK_EN
                    // A genuine pad always reports its four trailer bits high
                    if (&shift_q[NUM_BITS-NUM_BUTTONS-1:0]) begin
                        p1data_q <= ~shift_q[NUM_BITS-1 -: NUM_BUTTONS];
                        valid_q  <= 1'b1;
                    end
`else
                    p1data_q <= ~shift_q[NUM_BITS-1 -: NUM_BUTTONS];
                    valid_q  <= 1'b1;
`endif
                end
                default: begin
                    cnt_q   <= '0;
                    latch_q <= 1'b0;
                    clk_q   <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifndef SNES_FRAME_CHECK_EN
    logic w_unused_tail;
    assign w_unused_tail = ^shift_q[NUM_BITS-NUM_BUTTONS-1:0];
`endif

    assign ctrl_latch   = latch_q;
    assign ctrl_clk     = clk_q;
    assign p1data       = p1data_q;
    assign p1data_valid = valid_q;
    assign busy         = (state_q != IDLE);

endmodule

`default_nettype wire

// File: doc/snes_ctrl_reader.md
Name: snes_ctrl_reader

Overview:
- Drives one SNES-style game controller over its serial latch/clock/data interface and produces the parallel 12-bit button word `p1data[11:0]` consumed by the game-logic blocks.
- Polls autonomously once per frame period.
- Inverts the active-low serial data so that 1 = pressed, then registers the word with a one-cycle valid strobe.
- One instance per player, sitting between the FPGA pins and the game logic.

Parameters:
- HALF_TICKS, 288, system-clock cycles per half period of `ctrl_clk` (6 us at 48 MHz).
- FRAME_TICKS, 800000, system-clock cycles between frame starts (16.67 ms at 48 MHz). Must be >= 40*HALF_TICKS.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- ser_data  input  1  controller serial data, asynchronous, active-low per button
- ctrl_latch  output  1  controller latch pulse, active high
- ctrl_clk  output  1  controller clock, idles high
- p1data  output  12  button word, 1 = pressed; bit 11 = first serial bit (B) … bit 0 = R
- p1data_valid  output  1  one-cycle strobe, asserted when `p1data` updates
- busy  output  1  high while a frame transfer is in progress

Behaviour:
- Reset (async, reset_n=0):
  - ctrl_latch=0, ctrl_clk=1, p1data=0, p1data_valid=0, busy=0.
  - State=IDLE, frame timer=0, synchronizer flops=1.
  - Reset asserted mid-frame aborts the transfer immediately; no partial word is ever output.
- Input sync: ser_data passes through a 2-flop synchronizer; all samples use the synchronized value.
- Frame timer:
  - Free-running 0..FRAME_TICKS-1.
  - Start strobe when timer==FRAME_TICKS-1, so the first latch rises FRAME_TICKS cycles after reset release.
  - A start strobe that arrives outside IDLE is ignored.
- Half counter: counts HALF_TICKS cycles per state; the state exits when the count expires.
- FSM states:
  - IDLE: ctrl_clk=1, latch=0. On start strobe go to LATCH.
  - LATCH: ctrl_latch=1 for 2*HALF_TICKS cycles, then SETUP.
  - SETUP: latch=0, clk=1 for HALF_TICKS cycles. At exit, sample bit 0, then CLK_LO.
  - CLK_LO: ctrl_clk=0 for HALF_TICKS cycles, then CLK_HI. The rising edge shifts the controller.
  - CLK_HI: ctrl_clk=1 for HALF_TICKS cycles. At exit:
    - if bitcnt<15: sample bit bitcnt+1, increment bitcnt, go to CLK_LO;
    - if bitcnt==15: go to DONE.
  - DONE: one cycle. p1data <= ~shift[15:4] and p1data_valid=1 in the same cycle. Raw bits 12..15 are discarded. Then IDLE.
- Frame totals: 16 samples and 16 ctrl_clk low pulses. Latch rise to valid = 35*HALF_TICKS+1 cycles.
- busy=1 in every state except IDLE.
- Sampling: shift is MSB-first; the first sampled bit lands in shift[15].
- Output hold: p1data holds its value between strobes.

Optional Feature:
- Macro: SNES_FRAME_CHECK_EN.
- Defined:
  - At DONE, if any raw bit 12..15 is 0, the frame is discarded: p1data unchanged, p1data_valid stays 0.
  - This rejects unplugged or pulled-low data lines.
- Undefined: every completed frame updates p1data and strobes valid.

Decomposition:
- Package snes_pkg:
  - state enum (IDLE, LATCH, SETUP, CLK_LO, CLK_HI, DONE);
  - NUM_BITS=16, NUM_BUTTONS=12;
  - button index constants BTN_B=11, BTN_Y=10, BTN_SELECT=9, BTN_START=8, BTN_UP=7, BTN_DOWN=6, BTN_LEFT=5, BTN_RIGHT=4, BTN_A=3, BTN_X=2, BTN_L=1, BTN_R=0.
- Sub-module: sync_2ff (1-bit, reset value 1), reusable for other pin inputs.

Test Plan:
- Common setup:
  - HALF_TICKS=4, FRAME_TICKS=200.
  - Controller model: loads ~buttons on latch; its serial data output shows its current MSB; it shifts on ctrl_clk rising.
- Reset/timing: release reset -> outputs at reset values; ctrl_latch rises at cycle 200 and is high 8 cycles; exactly 16 ctrl_clk low pulses of 4 cycles each; busy high throughout.
- Model buttons 12'b000011100000 -> p1data=12'h0E0 with a single-cycle p1data_valid, 141 cycles after latch rise.
- Back-to-back frames: 12'b110100110010 then 12'h000 -> p1data=12'hD32 after frame 1 and 12'h000 after frame 2, changing only on valid; strobes are 200 cycles apart.
- reset_n pulsed low during CLK_LO of bit 7 -> ctrl_clk=1 and ctrl_latch=0 immediately, p1data=0, no valid; the next latch arrives 200 cycles after release.
- ser_data tied 1 -> p1data=0 with a valid pulse every frame.
- ser_data tied 0:
  - SNES_FRAME_CHECK_EN defined -> p1data keeps its prior value, no valid;
  - SNES_FRAME_CHECK_EN undefined -> p1data=12'hFFF with valid.
